// File: rtl/hex_ascii_pkg.sv
// hex_ascii_pkg: ASCII hex encoding/decoding shared by the transmit
// serializer (bin_to_hex_tx) and the receive-side hex accumulator.
// Contents:
//   ASCII_0/ASCII_UA/ASCII_LA  base codes for '0', 'A', 'a'
//   nibble_to_ascii(nib, upper) 4-bit value -> ASCII hex character
//   ascii_to_nibble(ch)         ASCII hex character -> {valid, nibble}
//   msd_index(word)             index of the highest non-zero nibble (0 for 0)
//   state_t                     serializer FSM states
package hex_ascii_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic upper);
    logic [7:0] ch;
    if (nib < 4'd10) ch = ASCII_0 + {4'h0, nib};
    else             ch = (upper ? ASCII_UA : ASCII_LA) + {4'h0, nib} - 8'd10;
    return ch;
  endfunction

  // Receive-side decoder: bit 4 flags a legal hex digit, bits 3:0 its value.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] ch);
    logic [4:0] r;
    r = 5'h00;
    if (ch >= ASCII_0 && ch <= 8'h39)
      r = {1'b1, 4'(ch - ASCII_0)};
    else if (ch >= ASCII_UA && ch <= 8'h46)
      r = {1'b1, 4'(ch - ASCII_UA + 8'd10)};
    else if (ch >= ASCII_LA && ch <= 8'h66)
      r = {1'b1, 4'(ch - ASCII_LA + 8'd10)};
    return r;
  endfunction

  // Callers zero-extend narrower words to 64 bits; ascending scan keeps the
  // highest non-zero nibble.
  function automatic logic [3:0] msd_index(input logic [63:0] word);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (word[4*i +: 4] != 4'd0) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ascii_hex_encode.sv
// ascii_hex_encode: combinational nibble -> ASCII hex character.
// Ports:
//   nib   in  4  nibble value 0..15
//   ascii out 8  '0'-'9', then 'A'-'F' (UPPER=1) or 'a'-'f' (UPPER=0)
module ascii_hex_encode
  import hex_ascii_pkg::*;
#(
  parameter bit UPPER = 1'b1
) (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  assign ascii = nibble_to_ascii(nib, UPPER);

endmodule

// File: rtl/bin_to_hex_tx.sv
// bin_to_hex_tx: serializes a binary word into ASCII hex characters, most
// significant digit first, one character per accepted output beat.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   bin_i/bin_valid_i word input; accepted while bin_ready_o (state IDLE)
//   ascii_o/valid_o/last_o  output character stream, ready_i backpressure
//   busy_o            word in flight
//   char_count_o      characters accepted downstream for the current word
//
// state | meaning
// IDLE  | waiting for a word, bin_ready_o=1
// EMIT  | streaming digits of word_q from idx down to 0
module bin_to_hex_tx
  import hex_ascii_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter bit UPPERCASE      = 1'b1,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin_i,
  input  logic             bin_valid_i,
  output logic             bin_ready_o,
  output logic [7:0]       ascii_o,
  output logic             valid_o,
  output logic             last_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic [5:0]       char_count_o
);

  localparam int         MAX_DIGITS = WIDTH / 4;
  localparam logic [3:0] LAST_IDX   = 4'(MAX_DIGITS - 1);

  state_t           state;
  logic [WIDTH-1:0] word_q;
  logic [3:0]       idx;
  logic [3:0]       first_idx;
  logic [3:0]       idx_nxt;
  logic [WIDTH-1:0] src;
  logic [3:0]       nib;
  logic [7:0]       char_nxt;

  assign bin_ready_o = (state == IDLE);
  assign busy_o      = (state == EMIT);

  assign first_idx = SUPPRESS_ZEROS ? msd_index(64'(bin_i)) : LAST_IDX;

  // One encoder serves both the first digit (straight from bin_i at the
  // handshake) and every following digit (from word_q), so the next
  // character is always registered one cycle ahead with no bubble.
  always_comb begin
    src     = word_q;
    idx_nxt = idx - 4'd1;
    if (state == IDLE) begin
      src     = bin_i;
      idx_nxt = first_idx;
    end
  end

  assign nib = 4'(src >> {idx_nxt, 2'b00});

  ascii_hex_encode #(.UPPER(UPPERCASE)) u_enc (
    .nib  (nib),
    .ascii(char_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_q       <= '0;
      idx          <= 4'd0;
      ascii_o      <= 8'h00;
      valid_o      <= 1'b0;
      last_o       <= 1'b0;
      char_count_o <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bin_valid_i) begin
            state        <= EMIT;
            word_q       <= bin_i;
            idx          <= first_idx;
            ascii_o      <= char_nxt;
            valid_o      <= 1'b1;
            last_o       <= (first_idx == 4'd0);
            char_count_o <= 6'd0;
          end
        end
        EMIT: begin
          if (valid_o && ready_i) begin
            char_count_o <= char_count_o + 6'd1;
            if (last_o) begin
              state   <= IDLE;
              valid_o <= 1'b0;
              last_o  <= 1'b0;
            end else begin
              idx     <= idx_nxt;
              ascii_o <= char_nxt;
              last_o  <= (idx_nxt == 4'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
